dat_rx_phy: RTL and testbench

Receive-side DAT line engine of the SD host controller, clocked on the SD card clock. After the DAT control logic arms it for a read transfer, it finds the start nibble on the 4-bit DAT bus and packs data nibbles into FIFO-width words. It checks the per-lane CRC16 and the end bit of every block, then writes words into the Rx buffer until all requested blocks arrive, an error occurs, or the transfer is aborted.

---
 rtl/dat_rx_phy_pkg.sv | 24 ++
 rtl/dat_rx_phy_crc16_lane.sv | 26 ++
 rtl/dat_rx_phy.sv | 188 ++++++++++++++++++
 tb/tb_dat_rx_phy.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dat_rx_phy_pkg.sv
// Shared definitions for the SD DAT receive engine: default widths, FSM
// encoding and the serial CRC16 step used by each lane.
package dat_rx_phy_pkg;
    localparam int FIFO_WIDTH      = 32;
    localparam int BLOCK_SZ_WIDTH  = 12;
    localparam int BLOCK_CNT_WIDTH = 16;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [3:0]  DAT_IDLE   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_CRC        = 3'd3,
        ST_END        = 3'd4
    } rx_state_t;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction
endpackage

// File: rtl/dat_rx_phy_crc16_lane.sv
// Serial CRC16 (x^16+x^12+x^5+1, zero seed) over one DAT lane.
module crc16_lane
    import dat_rx_phy_pkg::*;
(
    input  logic        sd_clk,
    input  logic        rst_L,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    // CRC register; clear wins so every block starts from a zero seed.
    always_ff @(posedge sd_clk or negedge rst_L) begin
        if (!rst_L) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end else begin
            crc <= crc;
        end
    end

endmodule

// File: rtl/dat_rx_phy.sv
// Receive-side DAT line engine: start detect, nibble packing, per-lane CRC16
// and end-bit check, with Rx buffer writes and sticky error flags.
module dat_rx_phy #(
    parameter int FIFO_WIDTH      = dat_rx_phy_pkg::FIFO_WIDTH,
    parameter int BLOCK_SZ_WIDTH  = dat_rx_phy_pkg::BLOCK_SZ_WIDTH,
    parameter int BLOCK_CNT_WIDTH = dat_rx_phy_pkg::BLOCK_CNT_WIDTH,
    parameter int TIMEOUT_CYC     = 1024
) (
    input  logic                       sd_clk,
    input  logic                       rst_L,
    input  logic                       rx_start,
    input  logic                       rx_abort,
    input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
    input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
    input  logic                       multiple_blk,
    input  logic [3:0]                 DAT_din,
    input  logic                       rx_buf_full,
    output logic                       rx_buf_wr,
    output logic [FIFO_WIDTH-1:0]      rx_buf_dout,
    output logic                       busy,
    output logic                       done,
    output logic                       crc_err,
    output logic                       timeout_err,
    output logic                       overrun_err
);
    import dat_rx_phy_pkg::*;

    localparam int NPW    = FIFO_WIDTH / 4;
    localparam int WPOS_W = (NPW > 1) ? $clog2(NPW) : 1;
    localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    rx_state_t                  state_r, state_s;
    logic [BLOCK_SZ_WIDTH:0]    nib_r;
    logic [WPOS_W-1:0]          wpos_r;
    logic [3:0]                 crc_cnt_r;
    logic [TMO_W-1:0]           tmo_r;
    logic [BLOCK_SZ_WIDTH-1:0]  blk_sz_r;
    logic [BLOCK_CNT_WIDTH-1:0] blk_left_r;
    logic [FIFO_WIDTH-1:0]      word_r;
    logic [3:0][15:0]           cmp_r;
    logic [3:0][15:0]           lane_crc_s;
    logic last_nib_s, word_done_s, tmo_hit_s, end_ok_s, last_blk_s, arm_s, word_end_s;
    logic fin_s, set_crc_s, set_tmo_s;

    assign last_nib_s  = ((nib_r + (BLOCK_SZ_WIDTH+1)'(1'b1)) == {blk_sz_r, 1'b0});
    assign word_done_s = (wpos_r == WPOS_W'(NPW - 1));
    assign tmo_hit_s   = (tmo_r == TMO_W'(TIMEOUT_CYC - 1));
    assign end_ok_s    = (cmp_r == lane_crc_s) && (DAT_din == DAT_IDLE);
    assign last_blk_s  = (blk_left_r == BLOCK_CNT_WIDTH'(1'b1));
    assign arm_s       = (state_r == ST_IDLE) && rx_start && !rx_abort;
    assign word_end_s  = (state_r == ST_DATA) && word_done_s && !rx_abort;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        crc16_lane u_crc (
            .sd_clk (sd_clk),
            .rst_L  (rst_L),
            .clr    (state_r == ST_WAIT_START),
            .en     (state_r == ST_DATA),
            .din    (DAT_din[k]),
            .crc    (lane_crc_s[k])
        );
    end

    // State register.
    always_ff @(posedge sd_clk or negedge rst_L) begin
        if (!rst_L) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and end-of-transfer events; abort overrides everything.
    always_comb begin
        state_s   = state_r;
        fin_s     = 1'b0;
        set_crc_s = 1'b0;
        set_tmo_s = 1'b0;
        if (rx_abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_start) state_s = ST_WAIT_START;
                    else          state_s = ST_IDLE;
                end
                ST_WAIT_START: begin
                    if (DAT_din == 4'h0) begin
                        state_s = ST_DATA;
                    end else if (tmo_hit_s) begin
                        state_s   = ST_IDLE;
                        fin_s     = 1'b1;
                        set_tmo_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT_START;
                    end
                end
                ST_DATA: begin
                    if (last_nib_s) state_s = ST_CRC;
                    else            state_s = ST_DATA;
                end
                ST_CRC: begin
                    if (crc_cnt_r == 4'd15) state_s = ST_END;
                    else                    state_s = ST_CRC;
                end
                ST_END: begin
                    if (!end_ok_s) begin
                        state_s   = ST_IDLE;
                        fin_s     = 1'b1;
                        set_crc_s = 1'b1;
                    end else if (last_blk_s) begin
                        state_s = ST_IDLE;
                        fin_s   = 1'b1;
                    end else begin
                        state_s = ST_WAIT_START;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Counters, word shifter and CRC compare registers.
    always_ff @(posedge sd_clk or negedge rst_L) begin
        if (!rst_L) begin
            nib_r      <= '0;
            wpos_r     <= '0;
            crc_cnt_r  <= 4'd0;
            tmo_r      <= '0;
            blk_sz_r   <= '0;
            blk_left_r <= '0;
            word_r     <= '0;
            cmp_r      <= '0;
        end else begin
            if (arm_s) begin
                blk_sz_r   <= block_sz;
                blk_left_r <= (!multiple_blk || block_cnt == '0) ? BLOCK_CNT_WIDTH'(1'b1) : block_cnt;
            end else if (state_r == ST_END && end_ok_s && !last_blk_s && !rx_abort) begin
                blk_left_r <= blk_left_r - BLOCK_CNT_WIDTH'(1'b1);
            end else begin
                blk_left_r <= blk_left_r;
            end
            tmo_r     <= (state_r == ST_WAIT_START) ? tmo_r + TMO_W'(1'b1) : '0;
            crc_cnt_r <= (state_r == ST_CRC) ? crc_cnt_r + 4'd1 : 4'd0;
            if (state_r == ST_DATA) begin
                nib_r  <= nib_r + (BLOCK_SZ_WIDTH+1)'(1'b1);
                wpos_r <= word_done_s ? '0 : wpos_r + WPOS_W'(1'b1);
                word_r <= {word_r[FIFO_WIDTH-5:0], DAT_din};
            end else begin
                nib_r  <= '0;
                wpos_r <= '0;
                word_r <= word_r;
            end
            for (int k = 0; k < 4; k++) begin
                if (state_r == ST_CRC) cmp_r[k] <= {cmp_r[k][14:0], DAT_din[k]};
                else                   cmp_r[k] <= cmp_r[k];
            end
        end
    end

    // Registered outputs: write strobe/data, status and sticky error flags.
    always_ff @(posedge sd_clk or negedge rst_L) begin
        if (!rst_L) begin
            rx_buf_wr   <= 1'b0;
            rx_buf_dout <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_buf_wr   <= word_end_s && !rx_buf_full;
            rx_buf_dout <= word_end_s ? {word_r[FIFO_WIDTH-5:0], DAT_din} : rx_buf_dout;
            busy        <= (state_s != ST_IDLE);
            done        <= fin_s;
            if (arm_s) begin
                crc_err     <= 1'b0;
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end else begin
                crc_err     <= crc_err | set_crc_s;
                timeout_err <= timeout_err | set_tmo_s;
                overrun_err <= overrun_err | (word_end_s && rx_buf_full);
            end
        end
    end

endmodule

// File: tb/tb_dat_rx_phy.sv
// Scoreboard bench for dat_rx_phy: stimulus pushes expected words, a negedge
// monitor pops and compares every Rx buffer write.
module tb_dat_rx_phy;
    localparam int FW  = 32;
    localparam int BSW = 12;
    localparam int BCW = 16;
    localparam int TMO = 16;

    logic           sd_clk = 1'b0;
    logic           rst_L = 1'b0;
    logic           rx_start = 1'b0;
    logic           rx_abort = 1'b0;
    logic [BSW-1:0] block_sz = '0;
    logic [BCW-1:0] block_cnt = '0;
    logic           multiple_blk = 1'b0;
    logic [3:0]     DAT_din = 4'hF;
    logic           rx_buf_full = 1'b0;
    logic           rx_buf_wr;
    logic [FW-1:0]  rx_buf_dout;
    logic           busy, done, crc_err, timeout_err, overrun_err;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int done_count = 0;
    logic [FW-1:0] exp_q[$];

    dat_rx_phy #(.FIFO_WIDTH(FW), .BLOCK_SZ_WIDTH(BSW), .BLOCK_CNT_WIDTH(BCW), .TIMEOUT_CYC(TMO)) dut (
        .sd_clk(sd_clk), .rst_L(rst_L), .rx_start(rx_start), .rx_abort(rx_abort),
        .block_sz(block_sz), .block_cnt(block_cnt), .multiple_blk(multiple_blk),
        .DAT_din(DAT_din), .rx_buf_full(rx_buf_full), .rx_buf_wr(rx_buf_wr),
        .rx_buf_dout(rx_buf_dout), .busy(busy), .done(done), .crc_err(crc_err),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge sd_clk) begin
        if (rx_buf_wr === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected actual=%0h required=none", rx_buf_dout);
            end else begin
                check("write_data", 64'(rx_buf_dout), 64'(exp_q.pop_front()));
            end
        end
        if (done === 1'b1) done_count++;
    end

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = {c[14:0], 1'b0};
        if (c[15] ^ b) r = r ^ 16'h1021;
        return r;
    endfunction

    task automatic drive(input logic [3:0] n, input logic full = 1'b0, input logic abort = 1'b0);
        DAT_din     = n;
        rx_buf_full = full;
        rx_abort    = abort;
        @(negedge sd_clk);
        rx_buf_full = 1'b0;
        rx_abort    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'hF);
    endtask

    task automatic arm(input int sz, input int cnt, input logic multi);
        block_sz     = BSW'(sz);
        block_cnt    = BCW'(cnt);
        multiple_blk = multi;
        DAT_din      = 4'hF;
        rx_start     = 1'b1;
        @(negedge sd_clk);
        rx_start     = 1'b0;
    endtask

    // blk < 0 selects the fixed 1,2,3,4,A,B,C,D pattern.
    task automatic send_block(input int blk, input int sz, input int drop_word,
                              input int bad_lane, input int bad_bit, input logic [3:0] end_nib);
        logic [15:0]   crc [4];
        logic [FW-1:0] w;
        logic [31:0]   pat;
        logic [3:0]    n;
        pat = 32'h1234ABCD;
        w   = '0;
        for (int k = 0; k < 4; k++) crc[k] = 16'h0000;
        drive(4'h0);
        for (int i = 0; i < 2 * sz; i++) begin
            if (blk < 0) n = pat[31 - 4 * i -: 4];
            else         n = 4'(i * 7 + blk * 5 + 3);
            for (int k = 0; k < 4; k++) crc[k] = crc_bit(crc[k], n[k]);
            w = {w[FW-5:0], n};
            if ((i % (FW / 4)) == (FW / 4) - 1) begin
                if (i / (FW / 4) != drop_word) exp_q.push_back(w);
                drive(n, (i / (FW / 4)) == drop_word);
            end else begin
                drive(n);
            end
        end
        for (int b = 15; b >= 0; b--) begin
            for (int k = 0; k < 4; k++) n[k] = crc[k][b] ^ ((k == bad_lane) && (b == bad_bit));
            drive(n);
        end
        drive(end_nib);
    endtask

    initial begin
        int w0, d0, first;

        repeat (3) @(negedge sd_clk);
        check("reset_outputs", 64'({rx_buf_wr, rx_buf_dout, busy, done, crc_err, timeout_err, overrun_err}), 64'd0);
        rst_L = 1'b1;
        idle(2);

        // Single block
        w0 = wr_count; d0 = done_count;
        arm(4, 1, 1'b0);
        check("single_busy", 64'(busy), 64'd1);
        send_block(-1, 4, -1, -1, -1, 4'hF);
        check("single_done", 64'({done, busy}), 64'b10);
        check("single_flags", 64'({crc_err, timeout_err, overrun_err}), 64'd0);
        idle(3);
        check("single_writes", 64'(wr_count - w0), 64'd1);
        check("single_done_cnt", 64'(done_count - d0), 64'd1);

        // Multi-block, back-to-back starts
        w0 = wr_count; d0 = done_count;
        arm(64, 4, 1'b1);
        for (int b = 0; b < 4; b++) begin
            send_block(b, 64, -1, -1, -1, 4'hF);
            if (b < 3) check("multi_mid", 64'({done, busy}), 64'b01);
        end
        check("multi_done", 64'({done, busy}), 64'b10);
        idle(3);
        check("multi_writes", 64'(wr_count - w0), 64'd64);
        check("multi_done_cnt", 64'(done_count - d0), 64'd1);
        check("multi_flags", 64'({crc_err, timeout_err, overrun_err}), 64'd0);

        // CRC error in block 2 of 4
        w0 = wr_count; d0 = done_count;
        arm(64, 4, 1'b1);
        send_block(10, 64, -1, -1, -1, 4'hF);
        send_block(11, 64, -1, 2, 5, 4'hF);
        check("crcerr_done", 64'({done, busy, crc_err}), 64'b101);
        idle(20);
        check("crcerr_writes", 64'(wr_count - w0), 64'd32);
        check("crcerr_done_cnt", 64'(done_count - d0), 64'd1);
        check("crcerr_idle", 64'(busy), 64'd0);

        // End bit error
        arm(4, 1, 1'b0);
        check("arm_clears_crc", 64'(crc_err), 64'd0);
        send_block(-1, 4, -1, -1, -1, 4'hE);
        check("endbit_err", 64'({done, crc_err}), 64'b11);
        idle(2);

        // Timeout
        w0 = wr_count; first = 0;
        arm(4, 1, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            drive(4'hF);
            if (done === 1'b1 && first == 0) first = k;
        end
        check("timeout_cycles", 64'(first), 64'd16);
        check("timeout_flags", 64'({timeout_err, crc_err}), 64'b10);
        check("timeout_writes", 64'(wr_count - w0), 64'd0);

        // Overrun on the 2nd word
        w0 = wr_count;
        arm(16, 1, 1'b0);
        send_block(20, 16, 1, -1, -1, 4'hF);
        check("overrun_flags", 64'({done, overrun_err, crc_err}), 64'b110);
        idle(2);
        check("overrun_writes", 64'(wr_count - w0), 64'd3);

        // Abort on the last nibble of the first word
        w0 = wr_count; d0 = done_count;
        arm(16, 1, 1'b0);
        drive(4'h0);
        for (int i = 1; i <= 7; i++) drive(4'(i));
        drive(4'h8, 1'b0, 1'b1);
        check("abort_idle", 64'({busy, done}), 64'b00);
        idle(3);
        check("abort_writes", 64'(wr_count - w0), 64'd0);
        check("abort_done_cnt", 64'(done_count - d0), 64'd0);
        check("abort_flags", 64'({crc_err, timeout_err, overrun_err}), 64'd0);

        // Reset mid-DATA
        arm(16, 1, 1'b0);
        drive(4'h0);
        exp_q.push_back(32'h12345678);
        for (int i = 1; i <= 10; i++) drive(4'(i));
        check("rst_pre_busy", 64'(busy), 64'd1);
        #2;
        rst_L = 1'b0;
        #1;
        check("rst_outputs", 64'({rx_buf_wr, rx_buf_dout, busy, done, crc_err, timeout_err, overrun_err}), 64'd0);
        @(negedge sd_clk);
        rst_L = 1'b1;
        idle(2);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
